// File: rtl/twos_complement_word_serializer.sv
// Purpose: accepts a WIDTH-bit word and streams it LSB-first to the bit-serial converter, with a per-word clear pulse.
// Latency: accept at edge T -> conv_reset in cycle T+1 -> bit k valid in cycle T+2+k; WIDTH+1 cycles per word sustained.
// Backpressure: in_ready only in IDLE or on the last bit; en=0 freezes CLEAR/SHIFT progress, and output bits are held stable.
module twos_complement_word_serializer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             ser_out,
  output logic             conv_reset,
  output logic             bit_valid,
  output logic             bit_last,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    SHIFT = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] shreg;
  logic [CW-1:0]    cnt;
  logic             accept;

  // Output decode is a pure function of the registers plus en, so a frozen stream keeps ser_out stable.
  always_comb begin
    ser_out    = shreg[0];
    conv_reset = (state == CLEAR);
    bit_valid  = (state == SHIFT) && en;
    bit_last   = bit_valid && (cnt == LAST);
    in_ready   = (state == IDLE) || bit_last;
    busy       = (state != IDLE);
    accept     = in_valid && in_ready;
  end

  // Word sequencing: a load on accept wins over shifting, which gives back-to-back words on the last bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      shreg <= '0;
      cnt   <= '0;
    end else if (accept) begin
      shreg <= in_data;
      cnt   <= '0;
      state <= CLEAR;
    end else begin
      case (state)
        CLEAR: begin
          if (en) begin
            state <= SHIFT;
          end
        end
        SHIFT: begin
          if (en) begin
            shreg <= shreg >> 1;
            if (cnt == LAST) begin
              cnt   <= '0;
              state <= IDLE;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_twos_complement_word_serializer.sv
// Bench for the word serializer: directed vector table, hand-written corner sequences,
// and a randomized run checked against a word-level reference model.
module tb_twos_complement_word_serializer;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         en;
  logic [W-1:0] in_data;
  logic         in_valid;
  logic         in_ready;
  logic         ser_out;
  logic         conv_reset;
  logic         bit_valid;
  logic         bit_last;
  logic         busy;

  int n_chk  = 0;
  int n_pass = 0;

  twos_complement_word_serializer #(.WIDTH(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .ser_out    (ser_out),
    .conv_reset (conv_reset),
    .bit_valid  (bit_valid),
    .bit_last   (bit_last),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // One row per clock cycle: inputs held for the cycle, outputs expected before the closing edge.
  typedef struct {
    bit         rst;
    bit         en;
    bit         vld;
    logic [7:0] dat;
    bit         chk;
    bit         chk_ser;
    logic [5:0] exp;   // {in_ready, ser_out, conv_reset, bit_valid, bit_last, busy}
  } row_t;

  row_t tbl[$];

  function automatic void add(bit rst, bit e, bit vld, logic [7:0] d, bit chk, bit cs,
                              bit rdy, bit ser, bit cr, bit bv, bit bl, bit bz);
    row_t r;
    r.rst = rst; r.en = e; r.vld = vld; r.dat = d; r.chk = chk; r.chk_ser = cs;
    r.exp = {rdy, ser, cr, bv, bl, bz};
    tbl.push_back(r);
  endfunction

  function automatic void idle_row(bit vld, logic [7:0] d);
    add(0, 1, vld, d, 1, 0, 1, 0, 0, 0, 0, 0);
  endfunction

  function automatic void clr_row(bit e, logic [7:0] d);
    add(0, e, 0, 8'h00, 1, 1, 0, d[0], 1, 0, 0, 1);
  endfunction

  function automatic void bit_row(bit e, logic [7:0] d, int k, bit vld, logic [7:0] vd);
    if (e) add(0, 1, vld, vd, 1, 1, (k == W-1), d[k], 0, 1, (k == W-1), 1);
    else   add(0, 0, vld, vd, 1, 1, 0, d[k], 0, 0, 0, 1);
  endfunction

  function automatic void bits(logic [7:0] d, int lo, int hi);
    for (int k = lo; k <= hi; k++) bit_row(1, d, k, 0, 8'h00);
  endfunction

  function automatic void build_table();
    // Reset for two cycles, then the idle state after release.
    add(1, 0, 0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0);
    add(1, 0, 0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 8'h00, 1, 1, 1, 0, 0, 0, 0, 0);
    // Single word 0x2C with en held high.
    idle_row(1, 8'h2C); clr_row(1, 8'h2C); bits(8'h2C, 0, 7); idle_row(0, 8'h00);
    // Back-to-back: 0xFF offered during the first word's last bit.
    idle_row(1, 8'h2C); clr_row(1, 8'h2C); bits(8'h2C, 0, 6);
    bit_row(1, 8'h2C, 7, 1, 8'hFF);
    clr_row(1, 8'hFF); bits(8'hFF, 0, 7); idle_row(0, 8'h00);
    // en dropped for two cycles in CLEAR and three cycles while bit 3 is presented.
    idle_row(1, 8'h2C); clr_row(0, 8'h2C); clr_row(0, 8'h2C); clr_row(1, 8'h2C);
    bits(8'h2C, 0, 2);
    for (int i = 0; i < 3; i++) bit_row(0, 8'h2C, 3, 0, 8'h00);
    bits(8'h2C, 3, 7); idle_row(0, 8'h00);
    // Reset while bit 5 is presented, then a fresh word 0x01.
    idle_row(1, 8'h2C); clr_row(1, 8'h2C); bits(8'h2C, 0, 4);
    add(1, 1, 0, 8'h00, 1, 1, 0, 1, 0, 1, 0, 1);
    add(0, 1, 0, 8'h00, 1, 1, 1, 0, 0, 0, 0, 0);
    idle_row(1, 8'h01); clr_row(1, 8'h01); bits(8'h01, 0, 7); idle_row(0, 8'h00);
    // 0xAA offered while busy before the last bit must be ignored.
    idle_row(1, 8'h2C); clr_row(1, 8'h2C); bits(8'h2C, 0, 2);
    bit_row(1, 8'h2C, 3, 1, 8'hAA); bit_row(1, 8'h2C, 4, 1, 8'hAA);
    bits(8'h2C, 5, 7); idle_row(0, 8'h00); idle_row(0, 8'h00);
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic check(string name, logic [31:0] got, logic [31:0] req);
    n_chk++;
    if (got === req) n_pass++;
    else $display("FAIL %s: got %0h required %0h", name, got, req);
  endtask

  task automatic check_outs(string name, logic [5:0] req, bit chk_ser);
    logic [5:0] got;
    logic [5:0] mask;
    got  = {in_ready, ser_out, conv_reset, bit_valid, bit_last, busy};
    mask = chk_ser ? 6'b111111 : 6'b101111;
    n_chk++;
    if (((got ^ req) & mask) == 6'b0 && !$isunknown(got & mask)) n_pass++;
    else $display("FAIL %s: rdy/ser/clr/bv/last/busy got %b required %b (mask %b)",
                  name, got, req, mask);
  endtask

  initial begin
    int         pos;
    int         idx;
    bit         pend;
    bit         done;
    bit         flip;
    bit         e_r;
    bit         v_r;
    bit         r_r;
    bit         p_bv;
    bit         p_bl;
    bit         p_rdy;
    logic [7:0] d_r;
    logic [7:0] cur;
    logic [7:0] conv_word;

    reset = 1'b1; en = 1'b0; in_valid = 1'b0; in_data = '0;
    next_cycle();

    // Directed vector table.
    build_table();
    for (int i = 0; i < tbl.size(); i++) begin
      reset = tbl[i].rst; en = tbl[i].en; in_valid = tbl[i].vld; in_data = tbl[i].dat;
      @(negedge clk);
      if (tbl[i].chk) check_outs($sformatf("row%0d", i), tbl[i].exp, tbl[i].chk_ser);
      next_cycle();
    end

    // Reset wins over a same-cycle handshake.
    reset = 1'b1; en = 1'b1; in_valid = 1'b1; in_data = 8'h5A;
    next_cycle();
    reset = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check_outs("reset_over_accept", 6'b100000, 1'b0);
    next_cycle();

    // End-to-end: 44 through a behavioural bit-serial two's complement converter gives 212.
    in_valid = 1'b1; in_data = 8'd44; en = 1'b1;
    next_cycle();
    in_valid = 1'b0;
    done = 0; flip = 0; idx = 0; conv_word = '0;
    for (int c = 0; c < 20 && !done; c++) begin
      @(negedge clk);
      if (conv_reset) begin flip = 0; idx = 0; end
      if (bit_valid && idx < W) begin
        conv_word[idx] = ser_out ^ flip;
        if (ser_out) flip = 1;
        idx++;
        if (bit_last) done = 1;
      end
      next_cycle();
    end
    check("e2e_done", {31'd0, done}, 32'd1);
    check("e2e_neg44", {24'd0, conv_word}, 32'd212);

    // Randomized run against a word-level model: pos=-1 idle, 0 clearing, k>0 presenting bit k-1.
    reset = 1'b1; in_valid = 1'b0; en = 1'b0;
    next_cycle();
    pos = -1; pend = 0; cur = '0; v_r = 0; d_r = '0;
    for (int c = 0; c < 1500; c++) begin
      r_r = ($urandom_range(0, 79) == 0);
      e_r = ($urandom_range(0, 3) != 0);
      if (!pend) begin
        v_r = ($urandom_range(0, 2) == 0);
        d_r = 8'($urandom);
      end
      reset = r_r; en = e_r; in_valid = v_r; in_data = d_r;
      @(negedge clk);
      p_bv  = (pos >= 1) && e_r;
      p_bl  = p_bv && (pos == W);
      p_rdy = (pos < 0) || p_bl;
      check_outs($sformatf("rand%0d", c),
                 {p_rdy, (pos >= 1) ? cur[pos-1] : cur[0], (pos == 0), p_bv, p_bl, (pos >= 0)},
                 (pos >= 0));
      pend = v_r && !(p_rdy && !r_r);
      if (r_r)                  pos = -1;
      else if (v_r && p_rdy)    begin cur = d_r; pos = 0; end
      else if (pos == 0 && e_r) pos = 1;
      else if (pos >= 1 && e_r) pos = (pos == W) ? -1 : pos + 1;
      next_cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
